// File: rtl/dmem_responder_if.sv
// Core-side load/store port and backing-memory req/ack port
// of the data-memory responder.
interface dmem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              cpu_we;
    logic              cpu_re;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wdata,
        input  mem_ack, mem_rdata,
        output cpu_rdata, stall,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wdata,
        output mem_ack, mem_rdata,
        input  cpu_rdata, stall,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: posted-store write buffer with load forwarding,
// in-order drain and blocking miss reads to a req/ack backing memory.
module dmem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);

    typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rdata_q;

    logic [ADDR_W-1:0] word_addr;
    logic [PW-1:0]     idx;
    logic [DATA_W-1:0] fwd_data;
    logic              full;
    logic              empty;
    logic              load;
    logic              hit;
    logic              miss;
    logic              push;
    logic              pop;
    logic              unused_addr;

    assign word_addr   = bus.cpu_addr[ADDR_W+1:2];
    assign unused_addr = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0]};
    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign load        = bus.cpu_re & ~bus.cpu_we;
    assign push        = bus.cpu_we & ~full;
    assign pop         = mem_req & mem_we & bus.mem_ack;
    assign miss        = load & ~hit;

    // Oldest to youngest, so the last match is the youngest store.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (((PW+1)'(i) < count) && (fifo_addr[idx] == word_addr)) begin
                hit      = 1'b1;
                fwd_data = fifo_data[idx];
            end
        end
    end

    assign bus.stall = reset &
        ((bus.cpu_we & full) | (miss & (state != RESP)));

    assign bus.cpu_rdata = !reset          ? '0 :
                           (state == RESP) ? rdata_q :
                           (load & hit)    ? fwd_data : '0;

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= word_addr;
            fifo_data[wr_ptr] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case (1'b1)
                push && !pop: count <= count + ONE_CNT;
                pop && !push: count <= count - ONE_CNT;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_req) begin
                        if (bus.mem_ack) mem_req <= 1'b0;
                        if (miss) state <= DRAIN;
                    end else if (miss && empty) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= word_addr;
                        state    <= READ;
                    end else if (miss) begin
                        state <= DRAIN;
                    end else if (!empty) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= fifo_addr[rd_ptr];
                        mem_wdata <= fifo_data[rd_ptr];
                    end
                end
                DRAIN: begin
                    if (mem_req) begin
                        if (bus.mem_ack) begin
                            mem_req <= 1'b0;
                            if (count == ONE_CNT) state <= READ;
                        end
                    end else if (empty) begin
                        state <= READ;
                    end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= fifo_addr[rd_ptr];
                        mem_wdata <= fifo_data[rd_ptr];
                    end
                end
                READ: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= word_addr;
                    end else if (bus.mem_ack) begin
                        mem_req <= 1'b0;
                        rdata_q <= bus.mem_rdata;
                        state   <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A simultaneous load and store is never issued by the core.
    a_no_we_re: assert property (
        @(posedge clk) disable iff (!reset) !(bus.cpu_we && bus.cpu_re)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with an ack-latency backing
// memory model that logs every completed transaction.
module tb_dmem_responder;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        ack_en = 1'b0;
    int          ack_lat = 0;
    logic        inject_ack = 1'b0;
    logic [31:0] rd_val = 32'h0;
    int          wait_cnt = 0;

    logic        log_we   [$];
    logic [9:0]  log_addr [$];
    logic [31:0] log_data [$];
    logic [9:0]  exp_addr [$];
    logic [31:0] exp_data [$];

    // Backing memory: acks ack_lat cycles after the first req cycle.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            bus.mem_ack   = inject_ack;
            bus.mem_rdata = rd_val;
            if (!bus.mem_req) begin
                wait_cnt = 0;
            end else if (ack_en) begin
                if (wait_cnt >= ack_lat) begin
                    bus.mem_ack = 1'b1;
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (bus.mem_req && bus.mem_ack) begin
                log_we.push_back(bus.mem_we);
                log_addr.push_back(bus.mem_addr);
                log_data.push_back(bus.mem_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (log_we.size() < n && k < 100) begin
            step();
            k++;
        end
    endtask

    task automatic wait_unstall(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (bus.stall && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", bus.mem_req); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 10'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
        n_cmp++; if (bus.cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus.cpu_rdata); end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_read();
        int cyc;
        clear_log();
        ack_en = 1'b0;
        bus.cpu_re = 1'b1; bus.cpu_addr = 32'h80;
        step();
        @(negedge clk);
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL mid_read_req: got req=%b we=%b want 1/0", bus.mem_req, bus.mem_we); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL async_rst_req: got %b want 0", bus.mem_req); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL async_rst_stall: got %b want 0", bus.stall); end
        bus.cpu_re = 1'b0;
        step(); step();
        reset = 1'b1;
        inject_ack = 1'b1;
        step();
        inject_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin n_bad++; $display("FAIL late_ack: got req=%b stall=%b want 0/0", bus.mem_req, bus.stall); end
        n_cmp++; if (bus.cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL late_ack_rdata: got %h want 0", bus.cpu_rdata); end
        // A buffered store must be discarded by reset.
        step();
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h60; bus.cpu_wdata = 32'h55;
        step();
        bus.cpu_we = 1'b0;
        step();
        @(negedge clk);
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL pend_write: got req=%b we=%b want 1/1", bus.mem_req, bus.mem_we); end
        #2 reset = 1'b0;
        step();
        reset = 1'b1;
        step(); step();
        @(negedge clk);
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_discard_req: got %b want 0", bus.mem_req); end
        step();
        bus.cpu_re = 1'b1; bus.cpu_addr = 32'h60;
        rd_val = 32'h0000600D;
        @(negedge clk);
        n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL rst_discard_fwd: got stall=%b want 1", bus.stall); end
        ack_en = 1'b1; ack_lat = 0;
        wait_unstall(cyc);
        n_cmp++; if (cyc >= 50) begin n_bad++; $display("FAIL discard_timeout: got %0d cycles want <50", cyc); end
        n_cmp++; if (bus.cpu_rdata !== 32'h0000600D) begin n_bad++; $display("FAIL discard_rdata: got %h want 0000600d", bus.cpu_rdata); end
        step();
        bus.cpu_re = 1'b0;
        n_cmp++; if (log_we.size() != 1) begin n_bad++; $display("FAIL discard_log: got %0d txns want 1", log_we.size()); end
        else begin
            n_cmp++; if (log_we[0] !== 1'b0 || log_addr[0] !== 10'h18) begin n_bad++; $display("FAIL discard_txn: got we=%b addr=%h want 0/018", log_we[0], log_addr[0]); end
        end
        step();
    endtask

    task automatic test_full_stall();
        clear_log();
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.cpu_we = 1'b1;
            bus.cpu_addr = 32'h10 + 32'(4 * i);
            bus.cpu_wdata = 32'hA0 + 32'(i);
            step();
        end
        bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'hA4;
        @(negedge clk);
        n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL full_stall: got %b want 1", bus.stall); end
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 10'h4 || bus.mem_wdata !== 32'hA0) begin
            n_bad++; $display("FAIL full_head: got req=%b we=%b addr=%h data=%h want 1/1/004/a0", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        ack_en = 1'b1; ack_lat = 0;
        step();
        @(negedge clk);
        ack_en = 1'b0;
        n_cmp++; if (bus.mem_ack !== 1'b1 || bus.stall !== 1'b1) begin n_bad++; $display("FAIL pop_same_cycle: got ack=%b stall=%b want 1/1", bus.mem_ack, bus.stall); end
        step();
        @(negedge clk);
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL after_pop_stall: got %b want 0", bus.stall); end
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL req_gap: got %b want 0", bus.mem_req); end
        step();
        bus.cpu_we = 1'b0;
        ack_en = 1'b1;
        wait_log(5);
        n_cmp++; if (log_we.size() != 5) begin n_bad++; $display("FAIL full_drain_cnt: got %0d want 5", log_we.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (log_we[i] !== 1'b1 || log_addr[i] !== 10'(4 + i) || log_data[i] !== 32'hA0 + 32'(i)) begin
                    n_bad++; $display("FAIL full_drain_%0d: got we=%b addr=%h data=%h want 1/%h/%h", i, log_we[i], log_addr[i], log_data[i], 10'(4 + i), 32'hA0 + 32'(i));
                end
            end
        end
        step(); step();
    endtask

    task automatic test_forward();
        clear_log();
        ack_en = 1'b0;
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'd11;
        step();
        bus.cpu_wdata = 32'd22;
        step();
        bus.cpu_we = 1'b0; bus.cpu_re = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.cpu_rdata !== 32'd22) begin n_bad++; $display("FAIL fwd_data: got %0d want 22", bus.cpu_rdata); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL fwd_stall: got %b want 0", bus.stall); end
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL fwd_no_read: got req=%b we=%b want 1/1", bus.mem_req, bus.mem_we); end
        step();
        bus.cpu_re = 1'b0;
        ack_en = 1'b1; ack_lat = 0;
        wait_log(2);
        n_cmp++; if (log_we.size() != 2) begin n_bad++; $display("FAIL fwd_log: got %0d want 2", log_we.size()); end
        else begin
            n_cmp++; if (log_we[0] !== 1'b1 || log_data[0] !== 32'd11 || log_addr[0] !== 10'h10) begin n_bad++; $display("FAIL fwd_w0: got we=%b addr=%h data=%0d want 1/010/11", log_we[0], log_addr[0], log_data[0]); end
            n_cmp++; if (log_we[1] !== 1'b1 || log_data[1] !== 32'd22 || log_addr[1] !== 10'h10) begin n_bad++; $display("FAIL fwd_w1: got we=%b addr=%h data=%0d want 1/010/22", log_we[1], log_addr[1], log_data[1]); end
        end
        step(); step();
    endtask

    task automatic test_miss_latency();
        int cyc;
        clear_log();
        ack_en = 1'b1; ack_lat = 3; rd_val = 32'hDEADBEEF;
        bus.cpu_re = 1'b1; bus.cpu_addr = 32'h80;
        wait_unstall(cyc);
        n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL miss_stall_cycles: got %0d want 5", cyc); end
        n_cmp++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL miss_rdata: got %h want deadbeef", bus.cpu_rdata); end
        step();
        bus.cpu_re = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL post_resp_rdata: got %h want 0", bus.cpu_rdata); end
        n_cmp++; if (log_we.size() != 1 || log_we[0] !== 1'b0 || log_addr[0] !== 10'h20) begin
            n_bad++; $display("FAIL miss_txn: got n=%0d want one read of 020", log_we.size());
        end
        step();
    endtask

    task automatic test_drain_then_read();
        int cyc;
        clear_log();
        ack_en = 1'b0;
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h300; bus.cpu_wdata = 32'hC0;
        step();
        bus.cpu_addr = 32'h304; bus.cpu_wdata = 32'hC1;
        step();
        bus.cpu_we = 1'b0; bus.cpu_re = 1'b1; bus.cpu_addr = 32'h100;
        rd_val = 32'h12345678;
        ack_en = 1'b1; ack_lat = 1;
        wait_unstall(cyc);
        n_cmp++; if (cyc >= 50) begin n_bad++; $display("FAIL drain_timeout: got %0d cycles want <50", cyc); end
        n_cmp++; if (bus.cpu_rdata !== 32'h12345678) begin n_bad++; $display("FAIL drain_rdata: got %h want 12345678", bus.cpu_rdata); end
        step();
        bus.cpu_re = 1'b0;
        n_cmp++; if (log_we.size() != 3) begin n_bad++; $display("FAIL drain_log: got %0d want 3", log_we.size()); end
        else begin
            n_cmp++; if (log_we[0] !== 1'b1 || log_addr[0] !== 10'hC0 || log_data[0] !== 32'hC0) begin n_bad++; $display("FAIL drain_w0: got we=%b addr=%h data=%h want 1/0c0/c0", log_we[0], log_addr[0], log_data[0]); end
            n_cmp++; if (log_we[1] !== 1'b1 || log_addr[1] !== 10'hC1 || log_data[1] !== 32'hC1) begin n_bad++; $display("FAIL drain_w1: got we=%b addr=%h data=%h want 1/0c1/c1", log_we[1], log_addr[1], log_data[1]); end
            n_cmp++; if (log_we[2] !== 1'b0 || log_addr[2] !== 10'h40) begin n_bad++; $display("FAIL drain_rd: got we=%b addr=%h want 0/040", log_we[2], log_addr[2]); end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int w;
        clear_log();
        exp_addr.delete();
        exp_data.delete();
        ack_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.cpu_we = 1'b1;
            bus.cpu_addr = 32'h400 + 32'(4 * k);
            bus.cpu_wdata = 32'h6000 + 32'(k);
            exp_addr.push_back(10'(32'h100 + 32'(k)));
            exp_data.push_back(32'h6000 + 32'(k));
            k++;
            step();
        end
        bus.cpu_we = 1'b0;
        for (int it = 0; it < 2 * DEPTH; it++) begin
            w = 0;
            while (!bus.mem_req && w < 10) begin step(); w++; end
            n_cmp++; if (w >= 10) begin n_bad++; $display("FAIL b2b_req_timeout_%0d: got no req want req", it); end
            bus.cpu_we = 1'b1;
            bus.cpu_addr = 32'h400 + 32'(4 * k);
            bus.cpu_wdata = 32'h6000 + 32'(k);
            exp_addr.push_back(10'(32'h100 + 32'(k)));
            exp_data.push_back(32'h6000 + 32'(k));
            k++;
            inject_ack = 1'b1;
            @(negedge clk);
            n_cmp++; if (bus.stall !== 1'b0 || bus.mem_ack !== 1'b1) begin n_bad++; $display("FAIL b2b_%0d: got stall=%b ack=%b want 0/1", it, bus.stall, bus.mem_ack); end
            step();
            bus.cpu_we = 1'b0;
            inject_ack = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            bus.cpu_we = 1'b1;
            bus.cpu_addr = 32'h400 + 32'(4 * k);
            bus.cpu_wdata = 32'h6000 + 32'(k);
            @(negedge clk);
            n_cmp++; if (bus.stall !== (i == 2)) begin n_bad++; $display("FAIL b2b_fill_%0d: got stall=%b want %b", i, bus.stall, i == 2); end
            if (i < 2) begin
                exp_addr.push_back(10'(32'h100 + 32'(k)));
                exp_data.push_back(32'h6000 + 32'(k));
                k++;
            end
            step();
        end
        bus.cpu_we = 1'b0;
        ack_en = 1'b1; ack_lat = 0;
        wait_log(exp_addr.size());
        n_cmp++; if (log_we.size() != exp_addr.size()) begin n_bad++; $display("FAIL b2b_log: got %0d want %0d", log_we.size(), exp_addr.size()); end
        else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                n_cmp++;
                if (log_we[i] !== 1'b1 || log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                    n_bad++; $display("FAIL b2b_order_%0d: got we=%b addr=%h data=%h want 1/%h/%h", i, log_we[i], log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_reset_mid_read();
        test_full_stall();
        test_forward();
        test_miss_latency();
        test_drain_then_read();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1);
    end
endmodule
